// File: rtl/toy_bus_pkg.sv
// Shared toy-bus definitions: field widths, opcode and id constants, and the
// response entry buffered by target-side nodes.
package toy_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_STRB_W = BUS_DATA_W / 8;
  localparam int unsigned BUS_ID_W   = 4;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } toy_op_e;

  localparam logic [BUS_ID_W-1:0] ID_INIT0 = 4'd0;
  localparam logic [BUS_ID_W-1:0] ID_INIT1 = 4'd1;
  localparam logic [BUS_ID_W-1:0] ID_DTCM  = 4'd2;

  // src_id is constant per node, so only the varying response fields are stored
  typedef struct packed {
    logic [BUS_DATA_W-1:0] data;
    toy_op_e               opcode;
    logic                  err;
    logic [BUS_ID_W-1:0]   tgt_id;
  } rsp_entry_t;

  // True when addr lies in the region of 4*2^word_aw bytes starting at base
  function automatic logic addr_hit(input logic [BUS_ADDR_W-1:0] addr,
                                    input logic [BUS_ADDR_W-1:0] base,
                                    input int unsigned           word_aw);
    return ((addr ^ base) >> (word_aw + 2)) == '0;
  endfunction

endpackage

// File: rtl/toy_bus_rsp_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide at any fill
// level, including full. DEPTH must be a power of two.
module toy_bus_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_rd_en = i_pop & ~o_empty;
  // a pop in the same cycle frees the slot, so a push at full is still taken
  assign w_wr_en = i_push & (~w_full | i_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/toy_bus_dtcm_rsp_node.sv
// DTCM target endpoint: performs toy-bus requests on a 1-cycle SRAM port and
// returns in-order responses on the initiator port chosen by requester id.
module toy_bus_dtcm_rsp_node
  import toy_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
  parameter int unsigned DEPTH     = 4,
  parameter logic [3:0]  SELF_ID   = ID_DTCM,
  parameter logic [3:0]  INIT1_ID  = ID_INIT1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_strb,
  input  logic [31:0]       req_data,
  input  logic              req_opcode,
  input  logic [3:0]        req_src_id,
  input  logic [3:0]        req_tgt_id,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp0_vld,
  input  logic              rsp0_rdy,
  output logic [31:0]       rsp0_data,
  output logic              rsp0_opcode,
  output logic              rsp0_err,
  output logic [3:0]        rsp0_src_id,
  output logic [3:0]        rsp0_tgt_id,
  output logic              rsp1_vld,
  input  logic              rsp1_rdy,
  output logic [31:0]       rsp1_data,
  output logic              rsp1_opcode,
  output logic              rsp1_err,
  output logic [3:0]        rsp1_src_id,
  output logic [3:0]        rsp1_tgt_id
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic             r_rdy_en;
  logic             r_s1_vld;
  toy_op_e          r_s1_op;
  logic             r_s1_err;
  logic [3:0]       r_s1_id;

  logic             w_accept;
  logic             w_hit;
  logic             w_empty;
  logic             w_head_vld;
  logic             w_to_rsp1;
  logic             w_pop;
  logic [CNT_W-1:0] w_count;
  logic [OCC_W-1:0] w_occ;
  rsp_entry_t       w_push_entry;
  rsp_entry_t       w_head;
  logic             w_unused;

  assign w_unused = ^{req_tgt_id, req_addr[1:0]};

  // Occupancy counts the entry still in stage 1 so a push can never hit a full FIFO
  assign w_occ    = OCC_W'(w_count) + OCC_W'(r_s1_vld);
  assign req_rdy  = r_rdy_en & (w_occ < OCC_W'(DEPTH));
  assign w_accept = req_vld & req_rdy;
  assign w_hit    = addr_hit(req_addr, BASE_ADDR, ADDR_W);

  assign mem_en    = w_accept & w_hit;
  assign mem_wen   = req_opcode;
  assign mem_addr  = req_addr[ADDR_W+1:2];
  assign mem_wstrb = req_strb;
  assign mem_wdata = req_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s1_op  <= OP_RD;
      r_s1_err <= 1'b0;
      r_s1_id  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_op  <= toy_op_e'(req_opcode);
        r_s1_err <= ~w_hit;
        r_s1_id  <= req_src_id;
      end
    end
  end

  always_comb begin
    w_push_entry        = '0;
    w_push_entry.opcode = r_s1_op;
    w_push_entry.err    = r_s1_err;
    w_push_entry.tgt_id = r_s1_id;
    if (r_s1_op == OP_RD && !r_s1_err) w_push_entry.data = mem_rdata;
  end

  toy_bus_rsp_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_s1_vld),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head_vld = ~w_empty;
  assign w_to_rsp1  = (w_head.tgt_id == INIT1_ID);
  assign rsp0_vld   = w_head_vld & ~w_to_rsp1;
  assign rsp1_vld   = w_head_vld & w_to_rsp1;
  assign w_pop      = (rsp0_vld & rsp0_rdy) | (rsp1_vld & rsp1_rdy);

  assign rsp0_data   = w_head.data;
  assign rsp0_opcode = w_head.opcode;
  assign rsp0_err    = w_head.err;
  assign rsp0_src_id = SELF_ID;
  assign rsp0_tgt_id = w_head.tgt_id;
  assign rsp1_data   = w_head.data;
  assign rsp1_opcode = w_head.opcode;
  assign rsp1_err    = w_head.err;
  assign rsp1_src_id = SELF_ID;
  assign rsp1_tgt_id = w_head.tgt_id;

endmodule

// File: tb/tb_toy_bus_dtcm_rsp_node.sv
// Directed bench for the DTCM response node with a behavioural 1-cycle SRAM.
module tb_toy_bus_dtcm_rsp_node;

  logic        clk;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] req_addr;
  logic [3:0]  req_strb;
  logic [31:0] req_data;
  logic        req_opcode;
  logic [3:0]  req_src_id;
  logic [3:0]  req_tgt_id;
  logic        mem_en;
  logic        mem_wen;
  logic [11:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rsp0_vld, rsp0_rdy, rsp0_opcode, rsp0_err;
  logic [31:0] rsp0_data;
  logic [3:0]  rsp0_src_id, rsp0_tgt_id;
  logic        rsp1_vld, rsp1_rdy, rsp1_opcode, rsp1_err;
  logic [31:0] rsp1_data;
  logic [3:0]  rsp1_src_id, rsp1_tgt_id;

  int n_cmp;
  int n_fail;

  logic [31:0] sram [4096];

  toy_bus_dtcm_rsp_node #(
    .ADDR_W    (12),
    .BASE_ADDR (32'h0002_0000),
    .DEPTH     (4),
    .SELF_ID   (4'd2),
    .INIT1_ID  (4'd1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_addr    (req_addr),
    .req_strb    (req_strb),
    .req_data    (req_data),
    .req_opcode  (req_opcode),
    .req_src_id  (req_src_id),
    .req_tgt_id  (req_tgt_id),
    .mem_en      (mem_en),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .rsp0_vld    (rsp0_vld),
    .rsp0_rdy    (rsp0_rdy),
    .rsp0_data   (rsp0_data),
    .rsp0_opcode (rsp0_opcode),
    .rsp0_err    (rsp0_err),
    .rsp0_src_id (rsp0_src_id),
    .rsp0_tgt_id (rsp0_tgt_id),
    .rsp1_vld    (rsp1_vld),
    .rsp1_rdy    (rsp1_rdy),
    .rsp1_data   (rsp1_data),
    .rsp1_opcode (rsp1_opcode),
    .rsp1_err    (rsp1_err),
    .rsp1_src_id (rsp1_src_id),
    .rsp1_tgt_id (rsp1_tgt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM with registered read data and byte-masked writes
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic op, input logic [3:0] s,
                       input logic [31:0] d, input logic [3:0] id);
    req_vld    = 1'b1;
    req_addr   = a;
    req_opcode = op;
    req_strb   = s;
    req_data   = d;
    req_src_id = id;
    req_tgt_id = 4'd2;
  endtask

  task automatic idle;
    req_vld = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    if (req_rdy !== 1'b0) begin $display("FAIL rst_rdy got %0b exp 0", req_rdy); n_fail++; end
    n_cmp++;
    if (rsp0_vld !== 1'b0 || rsp1_vld !== 1'b0) begin
      $display("FAIL rst_vld got %0b%0b exp 00", rsp0_vld, rsp1_vld); n_fail++; end
    n_cmp++;
    if (mem_en !== 1'b0) begin $display("FAIL rst_mem_en got %0b exp 0", mem_en); n_fail++; end
    n_cmp++;
    rst_n = 1'b1;
    #1;
    if (req_rdy !== 1'b0) begin $display("FAIL rel_rdy_pre got %0b exp 0", req_rdy); n_fail++; end
    n_cmp++;
    tick();
    if (req_rdy !== 1'b1) begin $display("FAIL rel_rdy got %0b exp 1", req_rdy); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_read;
    drive(32'h0002_0040, 1'b0, 4'hF, 32'h0, 4'd0);
    #1;
    if (mem_en !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 12'h010) begin
      $display("FAIL rd_mem got en=%0b wen=%0b addr=%h exp 1 0 010", mem_en, mem_wen, mem_addr);
      n_fail++; end
    n_cmp++;
    tick();
    idle();
    #1;
    if (rsp0_vld !== 1'b0) begin $display("FAIL rd_early got %0b exp 0", rsp0_vld); n_fail++; end
    n_cmp++;
    tick();
    if (rsp0_vld !== 1'b1 || rsp1_vld !== 1'b0) begin
      $display("FAIL rd_vld got %0b%0b exp 10", rsp0_vld, rsp1_vld); n_fail++; end
    n_cmp++;
    if (rsp0_data !== 32'hDEAD_BEEF) begin
      $display("FAIL rd_data got %h exp deadbeef", rsp0_data); n_fail++; end
    n_cmp++;
    if (rsp0_tgt_id !== 4'd0 || rsp0_src_id !== 4'd2 || rsp0_err !== 1'b0 || rsp0_opcode !== 1'b0) begin
      $display("FAIL rd_fields got tgt=%0d src=%0d err=%0b op=%0b exp 0 2 0 0",
               rsp0_tgt_id, rsp0_src_id, rsp0_err, rsp0_opcode); n_fail++; end
    n_cmp++;
    tick();
    if (rsp0_vld !== 1'b0) begin $display("FAIL rd_pop got %0b exp 0", rsp0_vld); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_write_read;
    drive(32'h0002_0044, 1'b1, 4'b0011, 32'h1234_5678, 4'd1);
    #1;
    if (mem_en !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 12'h011 ||
        mem_wstrb !== 4'b0011 || mem_wdata !== 32'h1234_5678) begin
      $display("FAIL wr_mem got en=%0b wen=%0b addr=%h strb=%b wd=%h exp 1 1 011 0011 12345678",
               mem_en, mem_wen, mem_addr, mem_wstrb, mem_wdata); n_fail++; end
    n_cmp++;
    tick();
    idle();
    tick();
    if (rsp1_vld !== 1'b1 || rsp0_vld !== 1'b0) begin
      $display("FAIL wr_route got rsp0=%0b rsp1=%0b exp 0 1", rsp0_vld, rsp1_vld); n_fail++; end
    n_cmp++;
    if (rsp1_data !== 32'h0 || rsp1_opcode !== 1'b1 || rsp1_tgt_id !== 4'd1 || rsp1_err !== 1'b0) begin
      $display("FAIL wr_ack got data=%h op=%0b tgt=%0d err=%0b exp 0 1 1 0",
               rsp1_data, rsp1_opcode, rsp1_tgt_id, rsp1_err); n_fail++; end
    n_cmp++;
    tick();
    drive(32'h0002_0044, 1'b0, 4'hF, 32'h0, 4'd0);
    tick();
    idle();
    tick();
    if (rsp0_vld !== 1'b1 || rsp0_data !== 32'hAABB_5678) begin
      $display("FAIL wr_readback got vld=%0b data=%h exp 1 aabb5678", rsp0_vld, rsp0_data); n_fail++; end
    n_cmp++;
    tick();
  endtask

  task automatic test_out_of_range;
    drive(32'h0003_0000, 1'b0, 4'hF, 32'h0, 4'd1);
    #1;
    if (mem_en !== 1'b0) begin $display("FAIL oor_mem_en got %0b exp 0", mem_en); n_fail++; end
    n_cmp++;
    tick();
    idle();
    tick();
    if (rsp1_vld !== 1'b1 || rsp0_vld !== 1'b0) begin
      $display("FAIL oor_route got rsp0=%0b rsp1=%0b exp 0 1", rsp0_vld, rsp1_vld); n_fail++; end
    n_cmp++;
    if (rsp1_err !== 1'b1 || rsp1_data !== 32'h0) begin
      $display("FAIL oor_rsp got err=%0b data=%h exp 1 0", rsp1_err, rsp1_data); n_fail++; end
    n_cmp++;
    tick();
  endtask

  task automatic test_zero_strb;
    drive(32'h0002_0080, 1'b1, 4'b0000, 32'hFFFF_FFFF, 4'd0);
    #1;
    if (mem_en !== 1'b1 || mem_wen !== 1'b1 || mem_wstrb !== 4'b0000) begin
      $display("FAIL zs_mem got en=%0b wen=%0b strb=%b exp 1 1 0000", mem_en, mem_wen, mem_wstrb);
      n_fail++; end
    n_cmp++;
    tick();
    idle();
    tick();
    if (rsp0_vld !== 1'b1 || rsp0_opcode !== 1'b1 || rsp0_data !== 32'h0) begin
      $display("FAIL zs_rsp got vld=%0b op=%0b data=%h exp 1 1 0", rsp0_vld, rsp0_opcode, rsp0_data);
      n_fail++; end
    n_cmp++;
    tick();
  endtask

  task automatic test_backpressure;
    int  k;
    logic acc;
    k = 0;
    rsp0_rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (k < 6) drive(32'h0002_0080 + 32'(4 * k), 1'b0, 4'hF, 32'h0, 4'd0);
      else idle();
      #1;
      acc = req_vld & req_rdy;
      tick();
      if (acc) k++;
    end
    idle();
    if (k !== 4) begin $display("FAIL bp_accepted got %0d exp 4", k); n_fail++; end
    n_cmp++;
    if (req_rdy !== 1'b0) begin $display("FAIL bp_rdy got %0b exp 0", req_rdy); n_fail++; end
    n_cmp++;
    rsp0_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rsp0_vld !== 1'b1 || rsp0_data !== 32'h100 + 32'(i)) begin
        $display("FAIL bp_drain%0d got vld=%0b data=%h exp 1 %h", i, rsp0_vld, rsp0_data, 32'h100 + 32'(i));
        n_fail++; end
      n_cmp++;
      tick();
    end
    if (rsp0_vld !== 1'b0 || req_rdy !== 1'b1) begin
      $display("FAIL bp_after got vld=%0b rdy=%0b exp 0 1", rsp0_vld, req_rdy); n_fail++; end
    n_cmp++;
    drive(32'h0002_0090, 1'b0, 4'hF, 32'h0, 4'd0);
    tick();
    drive(32'h0002_0094, 1'b0, 4'hF, 32'h0, 4'd0);
    tick();
    idle();
    if (rsp0_vld !== 1'b1 || rsp0_data !== 32'h104) begin
      $display("FAIL bp_resume0 got vld=%0b data=%h exp 1 104", rsp0_vld, rsp0_data); n_fail++; end
    n_cmp++;
    tick();
    if (rsp0_vld !== 1'b1 || rsp0_data !== 32'h105) begin
      $display("FAIL bp_resume1 got vld=%0b data=%h exp 1 105", rsp0_vld, rsp0_data); n_fail++; end
    n_cmp++;
    tick();
  endtask

  task automatic test_hol_routing;
    rsp0_rdy = 1'b0;
    rsp1_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h0002_0080 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 4'(i % 2));
      tick();
    end
    idle();
    for (int c = 0; c < 3; c++) begin
      if (rsp1_vld !== 1'b0 || rsp0_vld !== 1'b1 || rsp0_data !== 32'h100) begin
        $display("FAIL hol_stall%0d got rsp0=%0b rsp1=%0b data=%h exp 1 0 100", c, rsp0_vld, rsp1_vld, rsp0_data);
        n_fail++; end
      n_cmp++;
      tick();
    end
    rsp0_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        if (rsp0_vld !== 1'b1 || rsp1_vld !== 1'b0 || rsp0_data !== 32'h100 + 32'(i)) begin
          $display("FAIL hol_order%0d got rsp0=%0b rsp1=%0b data=%h exp 1 0 %h",
                   i, rsp0_vld, rsp1_vld, rsp0_data, 32'h100 + 32'(i)); n_fail++; end
      end else begin
        if (rsp1_vld !== 1'b1 || rsp0_vld !== 1'b0 || rsp1_data !== 32'h100 + 32'(i)) begin
          $display("FAIL hol_order%0d got rsp0=%0b rsp1=%0b data=%h exp 0 1 %h",
                   i, rsp0_vld, rsp1_vld, rsp1_data, 32'h100 + 32'(i)); n_fail++; end
      end
      n_cmp++;
      tick();
    end
    if (rsp0_vld !== 1'b0 || rsp1_vld !== 1'b0) begin
      $display("FAIL hol_empty got %0b%0b exp 00", rsp0_vld, rsp1_vld); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(32'h0002_0080 + 32'(4 * c), 1'b0, 4'hF, 32'h0, 4'd0);
      else idle();
      #1;
      if (c < 4) begin
        if (req_rdy !== 1'b1) begin $display("FAIL b2b_rdy%0d got %0b exp 1", c, req_rdy); n_fail++; end
        n_cmp++;
      end
      if (c >= 2) begin
        if (rsp0_vld !== 1'b1 || rsp0_data !== 32'h100 + 32'(c - 2)) begin
          $display("FAIL b2b_rsp%0d got vld=%0b data=%h exp 1 %h", c, rsp0_vld, rsp0_data, 32'h100 + 32'(c - 2));
          n_fail++; end
        n_cmp++;
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight;
    rsp0_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h0002_0080 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 4'd0);
      tick();
    end
    idle();
    tick();
    if (rsp0_vld !== 1'b1) begin $display("FAIL mid_buffered got %0b exp 1", rsp0_vld); n_fail++; end
    n_cmp++;
    rst_n = 1'b0;
    #1;
    if (rsp0_vld !== 1'b0 || rsp1_vld !== 1'b0 || req_rdy !== 1'b0) begin
      $display("FAIL mid_rst got rsp0=%0b rsp1=%0b rdy=%0b exp 0 0 0", rsp0_vld, rsp1_vld, req_rdy);
      n_fail++; end
    n_cmp++;
    tick();
    rst_n = 1'b1;
    #1;
    if (req_rdy !== 1'b0) begin $display("FAIL mid_rel_pre got %0b exp 0", req_rdy); n_fail++; end
    n_cmp++;
    tick();
    if (req_rdy !== 1'b1) begin $display("FAIL mid_rel_rdy got %0b exp 1", req_rdy); n_fail++; end
    n_cmp++;
    rsp0_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (rsp0_vld !== 1'b0 || rsp1_vld !== 1'b0) begin
        $display("FAIL mid_ghost%0d got %0b%0b exp 00", c, rsp0_vld, rsp1_vld); n_fail++; end
      n_cmp++;
      tick();
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    req_vld    = 1'b0;
    req_addr   = '0;
    req_strb   = '0;
    req_data   = '0;
    req_opcode = 1'b0;
    req_src_id = '0;
    req_tgt_id = '0;
    rsp0_rdy   = 1'b1;
    rsp1_rdy   = 1'b1;
    mem_rdata  = '0;
    for (int i = 0; i < 4096; i++) sram[i] = '0;
    sram[12'h010] = 32'hDEAD_BEEF;
    sram[12'h011] = 32'hAABB_CCDD;
    for (int i = 0; i < 6; i++) sram[12'h020 + 12'(i)] = 32'h100 + 32'(i);

    test_reset();
    test_read();
    test_write_read();
    test_out_of_range();
    test_zero_strb();
    test_back_to_back();
    test_backpressure();
    test_hol_routing();
    test_reset_midflight();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
